// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: byte/halfword/word access, configurable wait states and a
// two-cycle ERROR response for misaligned or oversized transfers.
module ahb_sram_slave #(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBUST,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic [1:0]  HRESP,
  output logic        HREADY
);

  localparam int unsigned IdxW      = $clog2(MEM_WORDS);
  localparam logic [1:0]  RespOkay  = 2'b00;
  localparam logic [1:0]  RespError = 2'b01;

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [IdxW-1:0]   idx_q;
  logic [1:0]        lo_q;
  logic [1:0]        size_q;
  logic              write_q;
  logic              hready_q;
  logic [1:0]        hresp_q;
  logic [31:0]       hrdata_q;

  logic [31:0]       mem [MEM_WORDS];

  logic              accept;
  logic              legal;
  logic [3:0]        be;
  logic              do_write;
  logic [IdxW-1:0]   rd_idx;
  logic              fwd;
  logic [31:0]       rd_word;

  logic              unused_inputs;
  assign unused_inputs = ^{HBUST, HTRANS[0], HADDR[31:IdxW+2]};

  assign accept = HSEL & HTRANS[1] & hready_q;

  always_comb begin
    legal = 1'b0;
    case (HSIZE)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~HADDR[0];
      3'b010:  legal = (HADDR[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    be = 4'b0000;
    case (size_q)
      2'b00:   be = 4'b0001 << lo_q;
      2'b01:   be = lo_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign do_write = (state_q == StData) & write_q;

  // The array is read at the edge that enters DATA; a write retiring on that same
  // edge is forwarded lane by lane so back-to-back read-after-write sees new data.
  assign rd_idx = (state_q == StWait) ? idx_q : HADDR[IdxW+1:2];
  assign fwd    = do_write & (rd_idx == idx_q);

  always_comb begin
    rd_word = mem[rd_idx];
    for (int i = 0; i < 4; i++) begin
      if (fwd && be[i]) rd_word[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESETn && do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      lo_q     <= 2'b00;
      size_q   <= 2'b00;
      write_q  <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= RespOkay;
      hrdata_q <= 32'h0;
    end else begin
      hrdata_q <= 32'h0;
      unique case (state_q)
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q  <= StData;
            hready_q <= 1'b1;
            if (!write_q) hrdata_q <= rd_word;
          end
        end
        StErr1: begin
          state_q  <= StErr2;
          hready_q <= 1'b1;
          hresp_q  <= RespError;
        end
        default: begin
          if (accept) begin
            idx_q   <= HADDR[IdxW+1:2];
            lo_q    <= HADDR[1:0];
            size_q  <= HSIZE[1:0];
            write_q <= HWRITE;
            if (!legal) begin
              state_q  <= StErr1;
              hready_q <= 1'b0;
              hresp_q  <= RespError;
            end else if (WAIT_STATES == 0) begin
              state_q  <= StData;
              hready_q <= 1'b1;
              hresp_q  <= RespOkay;
              if (!HWRITE) hrdata_q <= rd_word;
            end else begin
              state_q  <= StWait;
              cnt_q    <= 4'(WAIT_STATES);
              hready_q <= 1'b0;
              hresp_q  <= RespOkay;
            end
          end else begin
            state_q  <= StIdle;
            hready_q <= 1'b1;
            hresp_q  <= RespOkay;
          end
        end
      endcase
    end
  end

  assign HRDATA = hrdata_q;
  assign HRESP  = hresp_q;
  assign HREADY = hready_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: a zero-wait and a two-wait instance driven by a pipelined
// AHB master against a byte-lane memory model.
module tb_ahb_sram_slave;

  logic             HCLK = 1'b0;
  logic             HRESETn;
  logic [1:0]       hsel;
  logic [31:0]      haddr;
  logic [1:0]       htrans;
  logic             hwrite;
  logic [2:0]       hsize;
  logic [2:0]       hbust;
  logic [31:0]      hwdata;
  logic [1:0][31:0] hrdata;
  logic [1:0][1:0]  hresp;
  logic [1:0]       hready;

  always #5 HCLK = ~HCLK;

  ahb_sram_slave #(.MEM_WORDS(256), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBUST(hbust), .HWDATA(hwdata),
    .HRDATA(hrdata[0]), .HRESP(hresp[0]), .HREADY(hready[0])
  );

  ahb_sram_slave #(.MEM_WORDS(256), .WAIT_STATES(2)) u_dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBUST(hbust), .HWDATA(hwdata),
    .HRDATA(hrdata[1]), .HRESP(hresp[1]), .HREADY(hready[1])
  );

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t       tq[$];
  logic [31:0] mdl [2][256];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic        rdy_prev = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic int unsigned waits(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  // Legal when the size is at most a word and the address is a multiple of it.
  function automatic bit is_legal(input logic [31:0] a, input logic [2:0] s);
    int unsigned nb;
    if (s > 3'd2) return 1'b0;
    nb = 1 << s;
    return (a % nb) == 0;
  endfunction

  function automatic void apply_write(input int d, input xfer_t t);
    int unsigned nb   = 1 << t.size;
    int unsigned base = 32'(t.addr[1:0]);
    int unsigned w    = 32'(t.addr[9:2]);
    for (int k = 0; k < 4; k++) begin
      if (k >= base && k < base + nb) mdl[d][w][8*k +: 8] = t.wdata[8*k +: 8];
    end
  endfunction

  function automatic xfer_t mk(input logic wr, input logic [31:0] a, input logic [2:0] s,
                               input logic [31:0] wd);
    xfer_t t;
    t.write = wr; t.addr = a; t.size = s; t.wdata = wd;
    return t;
  endfunction

  task automatic check_outputs(input int d, input string tag, input logic er, input logic [1:0] ep,
                               input logic [31:0] ed);
    check({tag, "_hready"}, 32'(hready[d]), 32'(er));
    check({tag, "_hresp"},  32'(hresp[d]),  32'(ep));
    check({tag, "_hrdata"}, hrdata[d],      ed);
  endtask

  task automatic drive_idle(input int d);
    hsel    = '0;
    hsel[d] = 1'($urandom_range(1));
    htrans  = 2'($urandom_range(1));
    if ($urandom_range(3) == 0) begin
      hsel   = '0;
      htrans = 2'b10;
    end
    haddr  = $urandom;
    hwrite = 1'($urandom_range(1));
    hsize  = 3'($urandom_range(7));
  endtask

  // Pipelined master: issues the queue to DUT d, checking every cycle against the model.
  task automatic run_queue(input int d);
    xfer_t       ap, dp;
    bit          ap_v = 0, dp_v = 0;
    logic [1:0]  ap_tr = 2'b10;
    int unsigned ph = 0;
    int unsigned budget = 0;
    while (tq.size() > 0 || ap_v || dp_v) begin
      if (budget++ > 20000) begin
        check("timeout", 32'd0, 32'd1);
        tq.delete();
        break;
      end
      @(posedge HCLK); #1;
      if (rdy_prev && ap_v) begin
        dp = ap; dp_v = 1; ap_v = 0; ph = 0;
      end
      hwdata = dp_v ? dp.wdata : $urandom;
      if (!dp_v) begin
        check_outputs(d, "idle", 1'b1, 2'b00, 32'h0);
      end else if (is_legal(dp.addr, dp.size)) begin
        if (ph < waits(d)) begin
          check_outputs(d, "wait", 1'b0, 2'b00, 32'h0);
        end else begin
          check_outputs(d, dp.write ? "wdata" : "rdata", 1'b1, 2'b00,
                        dp.write ? 32'h0 : mdl[d][dp.addr[9:2]]);
          if (dp.write) apply_write(d, dp);
          dp_v = 0;
        end
      end else begin
        if (ph == 0) check_outputs(d, "err1", 1'b0, 2'b01, 32'h0);
        else begin
          check_outputs(d, "err2", 1'b1, 2'b01, 32'h0);
          dp_v = 0;
        end
      end
      ph++;
      rdy_prev = hready[d];
      if (!ap_v && tq.size() > 0 && $urandom_range(3) != 0) begin
        ap    = tq.pop_front();
        ap_v  = 1;
        ap_tr = 2'($urandom_range(3, 2));
      end
      if (ap_v) begin
        hsel    = '0;
        hsel[d] = 1'b1;
        htrans  = ap_tr;
        haddr   = ap.addr;
        hwrite  = ap.write;
        hsize   = ap.size;
      end else begin
        drive_idle(d);
      end
    end
  endtask

  task automatic push_directed();
    tq.push_back(mk(1'b1, 32'hF000_0010, 3'd2, 32'hDEAD_BEEF));
    tq.push_back(mk(1'b0, 32'hF000_0010, 3'd2, 32'h0));
    tq.push_back(mk(1'b1, 32'hF000_0020, 3'd2, 32'h1122_3344));
    tq.push_back(mk(1'b1, 32'hF000_0021, 3'd0, 32'h0000_AA00));
    tq.push_back(mk(1'b0, 32'hF000_0020, 3'd2, 32'h0));
    tq.push_back(mk(1'b1, 32'hF000_0022, 3'd1, 32'hBEEF_0000));
    tq.push_back(mk(1'b0, 32'hF000_0020, 3'd2, 32'h0));
    tq.push_back(mk(1'b1, 32'hF000_0002, 3'd2, 32'hFFFF_FFFF));
    tq.push_back(mk(1'b1, 32'hF000_0000, 3'd3, 32'hFFFF_FFFF));
    tq.push_back(mk(1'b1, 32'hF000_0001, 3'd1, 32'hFFFF_FFFF));
    tq.push_back(mk(1'b0, 32'hF000_0000, 3'd2, 32'h0));
  endtask

  task automatic push_random(input int n);
    logic [31:0] a;
    logic [2:0]  s;
    for (int i = 0; i < n; i++) begin
      s = ($urandom_range(9) == 0) ? 3'($urandom_range(7, 3)) : 3'($urandom_range(2));
      a = {($urandom_range(3) == 0) ? 22'($urandom) : 22'h3C_0000, 10'($urandom)};
      if ($urandom_range(4) != 0 && s <= 3'd2) a = a & ~((32'd1 << s) - 32'd1);
      tq.push_back(mk(1'($urandom_range(1)), a, s, $urandom));
    end
  endtask

  initial begin
    HRESETn = 1'b0;
    hsel    = '0;
    haddr   = 32'h0;
    htrans  = 2'b00;
    hwrite  = 1'b0;
    hsize   = 3'd0;
    hbust   = 3'd0;
    hwdata  = 32'h0;
    repeat (2) @(posedge HCLK);
    #1;
    for (int d = 0; d < 2; d++) check_outputs(d, "reset", 1'b1, 2'b00, 32'h0);
    HRESETn = 1'b1;
    repeat (3) begin
      @(posedge HCLK); #1;
      for (int d = 0; d < 2; d++) check_outputs(d, "post_reset_idle", 1'b1, 2'b00, 32'h0);
    end

    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 256; w++) tq.push_back(mk(1'b1, 32'hF000_0000 + 32'(4 * w), 3'd2,
                                                    $urandom));
      run_queue(d);
      push_directed();
      run_queue(d);
      push_random(400);
      run_queue(d);
    end

    // Reset during the wait of a write on the two-wait instance.
    @(posedge HCLK); #1;
    hsel   = 2'b10;
    htrans = 2'b10;
    haddr  = 32'hF000_0040;
    hwrite = 1'b1;
    hsize  = 3'd2;
    @(posedge HCLK); #1;
    check_outputs(1, "rst_mid_wait", 1'b0, 2'b00, 32'h0);
    hsel    = '0;
    htrans  = 2'b00;
    hwdata  = 32'hCAFE_F00D;
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    check_outputs(1, "rst_abort", 1'b1, 2'b00, 32'h0);
    HRESETn  = 1'b1;
    rdy_prev = 1'b1;
    tq.push_back(mk(1'b0, 32'hF000_0040, 3'd2, 32'h0));
    run_queue(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
